// File: rtl/mem_stage_pkg.sv
// Shared definitions for the M-stage memory bridge.
//   - ExcCode values raised or passed through by the bridge
//   - mem_size encodings
//   - device handshake FSM states
package mem_stage_pkg;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } devState_t;

endpackage

// File: rtl/mem_addr_decoder.sv
// Combinational address decoder for the M-stage bridge.
// Ports:
//   addr     in   effective address
//   memSize  in   access size (byte/half/word)
//   memWe    in   1 = store, 0 = load (selects AdES vs AdEL)
//   hitDm    out  address lies in data memory
//   hitDev   out  one-hot peripheral window hit
//   excCode  out  ExcCode for this access (EXC_NONE when legal)
module mem_addr_decoder
    import mem_stage_pkg::*;
#(
    parameter logic [31:0]           DM_TOP    = 32'h0000_2FFC,
    parameter int                    NUM_DEV   = 2,
    parameter logic [32*NUM_DEV-1:0] DEV_BASE  = {32'h7F10, 32'h7F00},
    parameter int                    DEV_SPAN  = 12,
    parameter int                    RO_OFFSET = 8
) (
    input  logic [31:0]        addr,
    input  logic [1:0]         memSize,
    input  logic               memWe,
    output logic               hitDm,
    output logic [NUM_DEV-1:0] hitDev,
    output logic [4:0]         excCode
);

    localparam logic [31:0] DM_LAST = DM_TOP + 32'd3;
    localparam logic [31:0] SPAN_W  = 32'(DEV_SPAN);
    localparam logic [31:0] RO_W    = 32'(RO_OFFSET);

    logic [NUM_DEV-1:0] roHit;
    logic               misaligned;
    logic [4:0]         badCode;

    assign hitDm = (addr <= DM_LAST);

    // The lower-bound test keeps the subtraction from wrapping into a false hit.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DEV; gi++) begin : g_win
            logic [31:0] offset;
            assign offset     = addr - DEV_BASE[32*gi +: 32];
            assign hitDev[gi] = (addr >= DEV_BASE[32*gi +: 32]) && (offset < SPAN_W);
            assign roHit[gi]  = hitDev[gi] && (offset == RO_W);
        end
    endgenerate

    always_comb begin
        misaligned = 1'b0;
        case (memSize)
            SIZE_BYTE: misaligned = 1'b0;
            SIZE_HALF: misaligned = addr[0];
            default:   misaligned = |addr[1:0];
        endcase
    end

    // Checks in priority order: range, alignment, size, read-only.
    always_comb begin
        badCode = memWe ? EXC_ADES : EXC_ADEL;
        excCode = EXC_NONE;
        if (!hitDm && !(|hitDev))
            excCode = badCode;
        else if (misaligned)
            excCode = badCode;
        else if ((|hitDev) && (memSize != SIZE_WORD))
            excCode = badCode;
        else if (memWe && (|roHit))
            excCode = EXC_ADES;
    end

endmodule

// File: rtl/mem_stage_bridge.sv
// M-stage memory bridge: routes loads/stores to single-cycle data memory or
// to peripheral windows through a req/ack handshake that stalls the pipeline.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   mem_re/mem_we/mem_size/mem_sext access control from M
//   addr, wdata                     effective address, forwarded store data
//   flush                           cancels the access in M
//   exc_in / exc_out                ExcCode in from E, out after M checks
//   rdata                           extended load result
//   stall                           freeze F..M
//   dm_*                            data memory interface (combinational read)
//   dev_*                           peripheral handshake interface
module mem_stage_bridge
    import mem_stage_pkg::*;
#(
    parameter logic [31:0]           DM_TOP    = 32'h0000_2FFC,
    parameter int                    NUM_DEV   = 2,
    parameter logic [32*NUM_DEV-1:0] DEV_BASE  = {32'h7F10, 32'h7F00},
    parameter int                    DEV_SPAN  = 12,
    parameter int                    RO_OFFSET = 8,
    parameter int                    TIMEOUT   = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mem_re,
    input  logic                    mem_we,
    input  logic [1:0]              mem_size,
    input  logic                    mem_sext,
    input  logic [31:0]             addr,
    input  logic [31:0]             wdata,
    input  logic                    flush,
    input  logic [4:0]              exc_in,
    output logic [4:0]              exc_out,
    output logic [31:0]             rdata,
    output logic                    stall,
    output logic                    dm_we,
    output logic [3:0]              dm_be,
    output logic [31:0]             dm_addr,
    output logic [31:0]             dm_wdata,
    input  logic [31:0]             dm_rdata,
    output logic                    dev_req,
    output logic [NUM_DEV-1:0]      dev_sel,
    output logic                    dev_we,
    output logic [31:0]             dev_addr,
    output logic [31:0]             dev_wdata,
    input  logic [32*NUM_DEV-1:0]   dev_rdata,
    input  logic [NUM_DEV-1:0]      dev_ack
);

    localparam int              CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic               hitDm;
    logic [NUM_DEV-1:0] hitDev;
    logic [4:0]         decExc;

    mem_addr_decoder #(
        .DM_TOP    (DM_TOP),
        .NUM_DEV   (NUM_DEV),
        .DEV_BASE  (DEV_BASE),
        .DEV_SPAN  (DEV_SPAN),
        .RO_OFFSET (RO_OFFSET)
    ) uDecoder (
        .addr    (addr),
        .memSize (mem_size),
        .memWe   (mem_we),
        .hitDm   (hitDm),
        .hitDev  (hitDev),
        .excCode (decExc)
    );

    devState_t          stateReg, stateNext;
    logic [CNT_W-1:0]   waitCntReg, waitCntNext;
    logic [NUM_DEV-1:0] devSelReg, devSelNext;
    logic               devWeReg, devWeNext;
    logic [31:0]        devAddrReg, devAddrNext;
    logic [31:0]        devWdataReg, devWdataNext;
    logic [31:0]        rdataReg, rdataNext;
    logic               timeoutReg, timeoutNext;
    logic               stallComb, devReqComb;

    logic        access, accessOk, launchDev, ackSel;
    logic [31:0] selData, laneWord, dmLoad;
    logic [31:0] maskedData [NUM_DEV];

    assign access    = (mem_re | mem_we) && (exc_in == EXC_NONE);
    assign accessOk  = access && (decExc == EXC_NONE);
    assign launchDev = accessOk && (|hitDev) && !flush && !reset;
    assign ackSel    = |(dev_ack & devSelReg);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DEV; gi++) begin : g_rd
            assign maskedData[gi] = dev_rdata[32*gi +: 32] & {32{devSelReg[gi]}};
        end
    endgenerate

    always_comb begin
        selData = '0;
        for (int i = 0; i < NUM_DEV; i++)
            selData = selData | maskedData[i];
    end

    always_comb begin
        stateNext    = stateReg;
        waitCntNext  = waitCntReg;
        devSelNext   = devSelReg;
        devWeNext    = devWeReg;
        devAddrNext  = devAddrReg;
        devWdataNext = devWdataReg;
        rdataNext    = rdataReg;
        timeoutNext  = timeoutReg;
        stallComb    = 1'b0;
        devReqComb   = 1'b0;
        case (stateReg)
            ST_IDLE: begin
                waitCntNext = '0;
                timeoutNext = 1'b0;
                if (launchDev) begin
                    stateNext    = ST_REQ;
                    stallComb    = 1'b1;
                    // The launch cycle counts as the first wait cycle, so the
                    // request is held exactly TIMEOUT cycles before giving up.
                    waitCntNext  = CNT_W'(1);
                    devSelNext   = hitDev;
                    devWeNext    = mem_we;
                    devAddrNext  = addr;
                    devWdataNext = wdata;
                end
            end
            ST_REQ: begin
                if (flush) begin
                    stateNext   = ST_IDLE;
                    waitCntNext = '0;
                    devSelNext  = '0;
                    devWeNext   = 1'b0;
                end else begin
                    stallComb  = 1'b1;
                    devReqComb = 1'b1;
                    if (ackSel) begin
                        stateNext = ST_DONE;
                        rdataNext = devWeReg ? 32'd0 : selData;
                    end else if (waitCntReg >= CNT_MAX) begin
                        stateNext   = ST_DONE;
                        timeoutNext = 1'b1;
                        rdataNext   = 32'd0;
                    end else begin
                        waitCntNext = waitCntReg + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                stateNext   = ST_IDLE;
                waitCntNext = '0;
                devSelNext  = '0;
                devWeNext   = 1'b0;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg    <= ST_IDLE;
            waitCntReg  <= '0;
            devSelReg   <= '0;
            devWeReg    <= 1'b0;
            devAddrReg  <= '0;
            devWdataReg <= '0;
            rdataReg    <= '0;
            timeoutReg  <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            waitCntReg  <= waitCntNext;
            devSelReg   <= devSelNext;
            devWeReg    <= devWeNext;
            devAddrReg  <= devAddrNext;
            devWdataReg <= devWdataNext;
            rdataReg    <= rdataNext;
            timeoutReg  <= timeoutNext;
        end
    end

    // Data memory path: lane select/extend for loads, lane replicate for stores.
    assign laneWord = dm_rdata >> {addr[1:0], 3'b000};

    always_comb begin
        dmLoad   = laneWord;
        dm_be    = 4'hF;
        dm_wdata = wdata;
        case (mem_size)
            SIZE_BYTE: begin
                dmLoad   = {{24{mem_sext & laneWord[7]}}, laneWord[7:0]};
                dm_be    = 4'b0001 << addr[1:0];
                dm_wdata = {4{wdata[7:0]}};
            end
            SIZE_HALF: begin
                dmLoad   = {{16{mem_sext & laneWord[15]}}, laneWord[15:0]};
                dm_be    = 4'b0011 << addr[1:0];
                dm_wdata = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign dm_addr = {addr[31:2], 2'b00};
    assign dm_we   = (stateReg == ST_IDLE) && accessOk && mem_we && hitDm && !flush && !reset;

    always_comb begin
        rdata = 32'd0;
        if (!reset) begin
            if (stateReg == ST_IDLE && mem_re && hitDm)
                rdata = dmLoad;
            else if (stateReg == ST_DONE)
                rdata = rdataReg;
        end
    end

    // An incoming ExcCode, a flush or reset all leave exc_out as exc_in.
    always_comb begin
        exc_out = exc_in;
        if (exc_in == EXC_NONE && !reset && !flush) begin
            case (stateReg)
                ST_IDLE: exc_out = access ? decExc : EXC_NONE;
                ST_DONE: exc_out = timeoutReg ? EXC_DBE : EXC_NONE;
                default: exc_out = EXC_NONE;
            endcase
        end
    end

    assign stall     = stallComb && !reset;
    assign dev_req   = devReqComb;
    assign dev_sel   = devSelReg;
    assign dev_we    = devWeReg;
    assign dev_addr  = devAddrReg;
    assign dev_wdata = devWdataReg;

endmodule

// File: tb/tb_mem_stage_bridge.sv
// Directed bench for mem_stage_bridge with a small data memory model and
// hand-driven peripheral acknowledges.
module tb_mem_stage_bridge;

    logic        clk = 1'b0;
    logic        reset, mem_re, mem_we, mem_sext, flush;
    logic [1:0]  mem_size;
    logic [31:0] addr, wdata;
    logic [4:0]  exc_in, exc_out;
    logic [31:0] rdata, dm_addr, dm_wdata, dm_rdata, dev_addr, dev_wdata;
    logic        stall, dm_we, dev_req, dev_we;
    logic [3:0]  dm_be;
    logic [1:0]  dev_sel, dev_ack;
    logic [63:0] dev_rdata;

    int checks = 0;
    int errors = 0;
    int reqCycles;

    logic [31:0] dmem [0:4095];

    always #5 clk = ~clk;

    mem_stage_bridge dut (
        .clk(clk), .reset(reset), .mem_re(mem_re), .mem_we(mem_we),
        .mem_size(mem_size), .mem_sext(mem_sext), .addr(addr), .wdata(wdata),
        .flush(flush), .exc_in(exc_in), .exc_out(exc_out), .rdata(rdata),
        .stall(stall), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dev_req(dev_req),
        .dev_sel(dev_sel), .dev_we(dev_we), .dev_addr(dev_addr),
        .dev_wdata(dev_wdata), .dev_rdata(dev_rdata), .dev_ack(dev_ack)
    );

    always @(posedge clk) begin
        if (dm_we) begin
            for (int b = 0; b < 4; b++)
                if (dm_be[b]) dmem[dm_addr[13:2]][8*b +: 8] <= dm_wdata[8*b +: 8];
        end
    end
    assign dm_rdata = dmem[dm_addr[13:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic nextCyc();
        @(posedge clk);
        #1;
    endtask

    task automatic acc(input logic re, input logic we, input logic [1:0] sz,
                       input logic sx, input logic [31:0] a, input logic [31:0] wd);
        mem_re = re; mem_we = we; mem_size = sz; mem_sext = sx; addr = a; wdata = wd;
    endtask

    task automatic idleIn();
        acc(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        flush = 1'b0; exc_in = 5'd0; dev_ack = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idleIn();
        dev_rdata = {32'h0000_BEEF, 32'h0000_CAFE};
        reset = 1'b1;
        acc(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
        exc_in = 5'd9;
        nextCyc();
        @(negedge clk);
        chk("rst_stall", stall, 0);
        chk("rst_dev_req", dev_req, 0);
        chk("rst_dev_sel", dev_sel, 0);
        chk("rst_dev_we", dev_we, 0);
        chk("rst_dm_we", dm_we, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_exc_out", exc_out, 9);
        nextCyc();
        reset = 1'b0;
        idleIn();

        // DM word store at the top word, then loads of several sizes
        acc(1'b0, 1'b1, 2'd2, 1'b0, 32'h2FFC, 32'h8000_00FF);
        @(negedge clk);
        chk("sw_top_we", dm_we, 1);
        chk("sw_top_be", dm_be, 4'hF);
        chk("sw_top_addr", dm_addr, 32'h2FFC);
        chk("sw_top_wdata", dm_wdata, 32'h8000_00FF);
        chk("sw_top_exc", exc_out, 0);
        nextCyc();
        acc(1'b1, 1'b0, 2'd2, 1'b0, 32'h2FFC, 32'h0);
        @(negedge clk);
        chk("lw_top", rdata, 32'h8000_00FF);
        chk("lw_top_we", dm_we, 0);
        nextCyc();
        acc(1'b1, 1'b0, 2'd0, 1'b1, 32'h2FFC, 32'h0);
        @(negedge clk);
        chk("lb_top_sext", rdata, 32'hFFFF_FFFF);
        chk("lb_top_stall", stall, 0);
        chk("lb_top_exc", exc_out, 0);
        nextCyc();
        acc(1'b1, 1'b0, 2'd0, 1'b0, 32'h2FFF, 32'h0);
        @(negedge clk);
        chk("lbu_last_byte", rdata, 32'h0000_0080);
        nextCyc();
        acc(1'b1, 1'b0, 2'd1, 1'b1, 32'h2FFE, 32'h0);
        @(negedge clk);
        chk("lh_top_sext", rdata, 32'hFFFF_8000);
        nextCyc();

        // Half store into the upper lane of word 0
        acc(1'b0, 1'b1, 2'd2, 1'b0, 32'h0, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("sw0_we", dm_we, 1);
        nextCyc();
        acc(1'b0, 1'b1, 2'd1, 1'b0, 32'h0002, 32'hABCD_1234);
        @(negedge clk);
        chk("sh2_be", dm_be, 4'b1100);
        chk("sh2_wdata", dm_wdata, 32'h1234_1234);
        chk("sh2_addr", dm_addr, 32'h0);
        chk("sh2_we", dm_we, 1);
        nextCyc();
        acc(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("lw0_after_sh", rdata, 32'h1234_FFFF);
        nextCyc();
        acc(1'b1, 1'b0, 2'd1, 1'b1, 32'h0002, 32'h0);
        @(negedge clk);
        chk("lh2_sext_pos", rdata, 32'h0000_1234);
        nextCyc();
        acc(1'b1, 1'b0, 2'd0, 1'b0, 32'h0001, 32'h0);
        @(negedge clk);
        chk("lbu1", rdata, 32'h0000_00FF);
        nextCyc();

        // Address exceptions
        acc(1'b1, 1'b0, 2'd1, 1'b0, 32'h0003, 32'h0);
        @(negedge clk);
        chk("lh3_exc", exc_out, 4);
        chk("lh3_dm_we", dm_we, 0);
        nextCyc();
        acc(1'b0, 1'b1, 2'd1, 1'b0, 32'h0003, 32'h5555);
        @(negedge clk);
        chk("sh3_exc", exc_out, 5);
        chk("sh3_dm_we", dm_we, 0);
        nextCyc();
        acc(1'b0, 1'b1, 2'd2, 1'b0, 32'h7F18, 32'h1);
        @(negedge clk);
        chk("sw_ro_exc", exc_out, 5);
        chk("sw_ro_stall", stall, 0);
        nextCyc();
        idleIn();
        @(negedge clk);
        chk("sw_ro_no_req", dev_req, 0);
        nextCyc();
        acc(1'b1, 1'b0, 2'd0, 1'b0, 32'h7F04, 32'h0);
        @(negedge clk);
        chk("lb_dev_exc", exc_out, 4);
        chk("lb_dev_stall", stall, 0);
        nextCyc();
        acc(1'b1, 1'b0, 2'd2, 1'b0, 32'h3000, 32'h0);
        @(negedge clk);
        chk("lw_3000_exc", exc_out, 4);
        nextCyc();
        acc(1'b0, 1'b1, 2'd2, 1'b0, 32'h7F0C, 32'h0);
        @(negedge clk);
        chk("sw_gap_exc", exc_out, 5);
        nextCyc();

        // Incoming exception and flush suppress side effects
        acc(1'b0, 1'b1, 2'd2, 1'b0, 32'h0100, 32'hDEAD_BEEF);
        exc_in = 5'd12;
        @(negedge clk);
        chk("excin_dm_we", dm_we, 0);
        chk("excin_exc", exc_out, 12);
        nextCyc();
        acc(1'b1, 1'b0, 2'd2, 1'b0, 32'h3000, 32'h0);
        @(negedge clk);
        chk("excin_over_range", exc_out, 12);
        nextCyc();
        acc(1'b1, 1'b0, 2'd2, 1'b0, 32'h7F04, 32'h0);
        @(negedge clk);
        chk("excin_dev_stall", stall, 0);
        nextCyc();
        @(negedge clk);
        chk("excin_dev_req", dev_req, 0);
        nextCyc();
        exc_in = 5'd0;
        acc(1'b0, 1'b1, 2'd2, 1'b0, 32'h0100, 32'hDEAD_BEEF);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_dm_we", dm_we, 0);
        nextCyc();
        idleIn();

        // Device 0 load, ack three cycles after launch, stray ack first
        acc(1'b1, 1'b0, 2'd2, 1'b0, 32'h7F04, 32'h0);
        @(negedge clk);
        chk("d0_c0_stall", stall, 1);
        chk("d0_c0_req", dev_req, 0);
        nextCyc();
        @(negedge clk);
        chk("d0_c1_req", dev_req, 1);
        chk("d0_c1_sel", dev_sel, 2'b01);
        chk("d0_c1_we", dev_we, 0);
        chk("d0_c1_addr", dev_addr, 32'h7F04);
        chk("d0_c1_stall", stall, 1);
        nextCyc();
        dev_ack = 2'b10;
        @(negedge clk);
        chk("d0_c2_stall", stall, 1);
        chk("d0_c2_req", dev_req, 1);
        nextCyc();
        dev_ack = 2'b01;
        @(negedge clk);
        chk("d0_c3_stall", stall, 1);
        nextCyc();
        dev_ack = 2'b00;
        @(negedge clk);
        chk("d0_done_stall", stall, 0);
        chk("d0_done_rdata", rdata, 32'h0000_CAFE);
        chk("d0_done_req", dev_req, 0);
        chk("d0_done_sel", dev_sel, 2'b01);
        chk("d0_done_exc", exc_out, 0);
        nextCyc();
        idleIn();
        @(negedge clk);
        chk("d0_idle_stall", stall, 0);
        chk("d0_idle_sel", dev_sel, 0);
        nextCyc();

        // Device 1 store with no ack: timeout
        acc(1'b0, 1'b1, 2'd2, 1'b0, 32'h7F10, 32'h55);
        @(negedge clk);
        chk("to_c0_stall", stall, 1);
        nextCyc();
        reqCycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dev_req !== 1'b1) break;
            if (i == 0) begin
                chk("to_we", dev_we, 1);
                chk("to_sel", dev_sel, 2'b10);
                chk("to_wdata", dev_wdata, 32'h55);
            end
            reqCycles++;
            nextCyc();
        end
        chk("to_req_cycles", reqCycles, 15);
        chk("to_exc", exc_out, 7);
        chk("to_stall", stall, 0);
        nextCyc();
        idleIn();
        @(negedge clk);
        chk("to_after_exc", exc_out, 0);
        nextCyc();

        // Ack in the first request cycle: two-cycle latency
        acc(1'b1, 1'b0, 2'd2, 1'b0, 32'h7F10, 32'h0);
        dev_ack = 2'b10;
        @(negedge clk);
        chk("fast_c0_stall", stall, 1);
        nextCyc();
        @(negedge clk);
        chk("fast_c1_req", dev_req, 1);
        chk("fast_c1_stall", stall, 1);
        nextCyc();
        dev_ack = 2'b00;
        @(negedge clk);
        chk("fast_done_stall", stall, 0);
        chk("fast_done_rdata", rdata, 32'h0000_BEEF);
        nextCyc();
        idleIn();

        // Flush during the request aborts without an exception
        acc(1'b1, 1'b0, 2'd2, 1'b0, 32'h7F10, 32'h0);
        @(negedge clk);
        nextCyc();
        @(negedge clk);
        chk("fl_c1_req", dev_req, 1);
        nextCyc();
        flush = 1'b1;
        @(negedge clk);
        chk("fl_req", dev_req, 0);
        chk("fl_stall", stall, 0);
        chk("fl_exc", exc_out, 0);
        nextCyc();
        idleIn();
        @(negedge clk);
        chk("fl_idle_req", dev_req, 0);
        chk("fl_idle_stall", stall, 0);
        chk("fl_idle_exc", exc_out, 0);
        chk("fl_idle_sel", dev_sel, 0);
        chk("fl_idle_rdata", rdata, 0);
        nextCyc();

        // Reset in the middle of a request
        acc(1'b1, 1'b0, 2'd2, 1'b0, 32'h7F04, 32'h0);
        @(negedge clk);
        nextCyc();
        @(negedge clk);
        chk("rq_c1_req", dev_req, 1);
        nextCyc();
        reset = 1'b1;
        nextCyc();
        @(negedge clk);
        chk("rq_rst_req", dev_req, 0);
        chk("rq_rst_stall", stall, 0);
        chk("rq_rst_sel", dev_sel, 0);
        chk("rq_rst_exc", exc_out, 0);
        nextCyc();
        reset = 1'b0;
        idleIn();
        @(negedge clk);
        chk("rq_after_req", dev_req, 0);
        chk("rq_after_stall", stall, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
